// File: rtl/lcd_pkg.sv
// lcd_pkg: panel geometry defaults, FSM state and pixel types shared by the raster controller
package lcd_pkg;
  localparam int H_ACT_D  = 480;
  localparam int H_FP_D   = 2;
  localparam int H_SYNC_D = 41;
  localparam int H_BP_D   = 2;
  localparam int V_ACT_D  = 272;
  localparam int V_FP_D   = 2;
  localparam int V_SYNC_D = 10;
  localparam int V_BP_D   = 2;
  localparam int CW_D     = 10;
  localparam int H_TOT_D  = H_ACT_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOT_D  = V_ACT_D + V_FP_D + V_SYNC_D + V_BP_D;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
endpackage

// File: rtl/lcd_timing_counter.sv
// lcd_timing_counter: h/v raster counters with wrap flags and active/sync decode
module lcd_timing_counter
  import lcd_pkg::*;
#(
  parameter int H_ACT  = H_ACT_D,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_ACT  = V_ACT_D,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D,
  parameter int CW     = CW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          line_end,
  output logic          frame_end,
  output logic          act,
  output logic          hs_n,
  output logic          vs_n
);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  // next counter values plus position decode of the current counters
  always_comb begin
    line_end  = h_q == CW'(H_TOT - 1);
    frame_end = line_end && v_q == CW'(V_TOT - 1);
    h_d = clr ? '0 : !inc ? h_q : line_end ? '0 : h_q + CW'(1);
    v_d = clr ? '0 : !(inc && line_end) ? v_q : frame_end ? '0 : v_q + CW'(1);
    act  = h_q < CW'(H_ACT) && v_q < CW'(V_ACT);
    hs_n = !(h_q >= CW'(H_ACT + H_FP) && h_q < CW'(H_ACT + H_FP + H_SYNC));
    vs_n = !(v_q >= CW'(V_ACT + V_FP) && v_q < CW'(V_ACT + V_FP + V_SYNC));
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
  assign h = h_q;
  assign v = v_q;
endmodule

// File: rtl/lcd_raster_ctrl.sv
// lcd_raster_ctrl: start/stop raster scan sequencer driving an LCD model from a pixel source
module lcd_raster_ctrl
  import lcd_pkg::*;
#(
  parameter int H_ACT  = H_ACT_D,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_ACT  = V_ACT_D,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D,
  parameter int CW     = CW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] src_x,
  output logic [CW-1:0] src_y,
  output logic          src_act,
  input  logic [7:0]    src_r,
  input  logic [7:0]    src_g,
  input  logic [7:0]    src_b,
  output logic [CW-1:0] lcd_x,
  output logic [CW-1:0] lcd_y,
  output logic [7:0]    lcd_r,
  output logic [7:0]    lcd_g,
  output logic [7:0]    lcd_b,
  output logic          lcd_de,
  output logic          lcd_hsync,
  output logic          lcd_vsync,
  output logic          frame_start,
  output logic          busy,
  output logic [15:0]   frame_cnt
);
  state_e        state_q, state_d;
  logic [CW-1:0] h, v;
  logic          line_end, frame_end, act, hs_n, vs_n, idle;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  rgb888_t       rgb_q, rgb_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [15:0]   cnt_q, cnt_d;

  lcd_timing_counter #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CW(CW)
  ) u_cnt (
    .clk(clk), .rst(rst), .clr(idle), .inc(!idle),
    .h(h), .v(v), .line_end(line_end), .frame_end(frame_end),
    .act(act), .hs_n(hs_n), .vs_n(vs_n)
  );

  // scan FSM: STOP keeps scanning and only drops to IDLE at the frame boundary
  always_comb begin
    idle    = state_q == IDLE;
    state_d = en ? RUN : idle ? IDLE : (state_q == STOP && frame_end) ? IDLE : STOP;
  end

  // stage-1 next values: coordinates hold their last active value during blanking
  always_comb begin
    src_act = act && !idle;
    de_d    = src_act;
    x_d     = src_act ? h : x_q;
    y_d     = src_act ? v : y_q;
    rgb_d   = src_act ? rgb888_t'({src_r, src_g, src_b}) : '0;
    hs_d    = idle ? 1'b1 : hs_n;
    vs_d    = idle ? 1'b1 : vs_n;
    fs_d    = src_act && h == '0 && v == '0;
    cnt_d   = cnt_q + {15'd0, fs_d};
  end

  // state and output pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign src_x       = h;
  assign src_y       = v;
  assign lcd_x       = x_q;
  assign lcd_y       = y_q;
  assign lcd_r       = rgb_q.r;
  assign lcd_g       = rgb_q.g;
  assign lcd_b       = rgb_q.b;
  assign lcd_de      = de_q;
  assign lcd_hsync   = hs_q;
  assign lcd_vsync   = vs_q;
  assign frame_start = fs_q;
  assign busy        = !idle;
  assign frame_cnt   = cnt_q;
endmodule
